// File: rtl/tilt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tilt_pkg                                                   |
// | Description : Shared state encoding, thresholds and helpers for the      |
// |               tilt-to-letter sequencer and decoder.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package tilt_pkg;

  // Sequencer state encoding
  localparam logic [2:0] S_WAIT_TICK = 3'd0;
  localparam logic [2:0] S_LATCH     = 3'd1;
  localparam logic [2:0] S_WAIT_DEC  = 3'd2;
  localparam logic [2:0] S_COMPARE   = 3'd3;
  localparam logic [2:0] S_EMIT      = 3'd4;
  localparam logic [2:0] S_REARM     = 3'd5;

  typedef enum logic [2:0] {
    WAIT_TICK = S_WAIT_TICK,
    LATCH     = S_LATCH,
    WAIT_DEC  = S_WAIT_DEC,
    COMPARE   = S_COMPARE,
    EMIT      = S_EMIT,
    REARM     = S_REARM
  } state_t;

  // Decoder thresholds: letters start at ENTRY_THRES, one letter per step
  localparam logic signed [11:0] ENTRY_THRES = 12'sd500;
  localparam logic signed [11:0] THRES_STEP  = 12'sd50;
  localparam logic [7:0]         ASCII_A     = 8'd65;
  localparam int                 NUM_LETTERS = 13;

  // True when every axis is strictly below the threshold (signed compare)
  function automatic logic all_below(
    input logic signed [11:0] x,
    input logic signed [11:0] y,
    input logic signed [11:0] z,
    input logic signed [11:0] thr
  );
    return (x < thr) && (y < thr) && (z < thr);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tilt_letter_ctrl_tick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sample_tick_gen                                            |
// | Description : Free-running divider producing a one-cycle sample tick     |
// |               every SAMPLE_DIV clock cycles.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int c_cnt_w = $clog2(SAMPLE_DIV);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SAMPLE_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Count 0..SAMPLE_DIV-1 and wrap, regardless of what the sequencer does
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_cnt_last);

endmodule
`default_nettype wire

// File: rtl/tilt_letter_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tilt_letter_ctrl                                           |
// | Description : Samples the accelerometer on a fixed tick, drives the      |
// |               decoder, debounces its ASCII output and hands accepted     |
// |               letters downstream on a valid/ready handshake.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tilt_letter_ctrl #(
  parameter int                 SAMPLE_DIV    = 100000,
  parameter int                 STABLE_COUNT  = 4,
  parameter int                 DEC_TIMEOUT   = 8,
  parameter logic signed [11:0] ENTRY_THRES   = tilt_pkg::ENTRY_THRES,
  parameter logic signed [11:0] NEUTRAL_THRES = 12'sd200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [11:0] accel_x,
  input  logic signed [11:0] accel_y,
  input  logic signed [11:0] accel_z,
  output logic signed [11:0] dec_x,
  output logic signed [11:0] dec_y,
  output logic signed [11:0] dec_z,
  input  logic [7:0]         dec_ascii,
  input  logic               dec_valid,
  output logic [7:0]         char_out,
  output logic               char_valid,
  input  logic               char_ready,
  output logic               busy,
  output logic               timeout_err
);

  import tilt_pkg::*;

  localparam int c_cnt_w = $clog2(STABLE_COUNT + 1);
  localparam int c_to_w  = $clog2(DEC_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_stable  = c_cnt_w'(STABLE_COUNT);
  localparam logic [c_to_w-1:0]  c_to_last = c_to_w'(DEC_TIMEOUT - 1);

  state_t                r_state;
  state_t                w_next;
  logic signed [11:0]    r_dec_x, r_dec_y, r_dec_z;
  logic [7:0]            r_cand;
  logic [c_cnt_w-1:0]    r_count;
  logic [7:0]            r_sample_code;
  logic [7:0]            r_char_out;
  logic [c_to_w-1:0]     r_to_cnt;
  logic                  r_timeout_err;

  logic                  w_tick;
  logic                  w_entry_below;
  logic                  w_neutral;
  logic                  w_to_expire;
  logic                  w_timeout;
  logic                  w_match;
  logic [c_cnt_w-1:0]    w_cnt_new;
  logic [7:0]            w_cand_new;

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_entry_below = all_below(accel_x, accel_y, accel_z, ENTRY_THRES);
  assign w_neutral     = all_below(accel_x, accel_y, accel_z, NEUTRAL_THRES);
  assign w_to_expire   = (r_to_cnt == c_to_last);

  // Debounce arithmetic: extend the run on a repeat, otherwise restart at 1
  always_comb begin
    w_match    = (r_sample_code == r_cand) && (r_count != '0);
    w_cand_new = r_sample_code;
    w_cnt_new  = c_cnt_w'(1);
    if (w_match) begin
      w_cnt_new = (r_count >= c_stable) ? c_stable : r_count + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WAIT_TICK;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a valid on the expiry cycle wins over the timeout
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      WAIT_TICK: if (w_tick) w_next = LATCH;
      LATCH:     w_next = w_entry_below ? WAIT_TICK : WAIT_DEC;
      WAIT_DEC: begin
        if (dec_valid) begin
          w_next = COMPARE;
        end else if (w_to_expire) begin
          w_next    = WAIT_TICK;
          w_timeout = 1'b1;
        end
      end
      COMPARE:   w_next = (w_cnt_new == c_stable) ? EMIT : WAIT_TICK;
      EMIT:      if (char_ready) w_next = REARM;
      REARM:     if (w_tick && w_neutral) w_next = WAIT_TICK;
      default:   w_next = WAIT_TICK;
    endcase
  end

  // Datapath: held decoder sample, candidate/run tracking, timeout, letter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dec_x       <= '0;
      r_dec_y       <= '0;
      r_dec_z       <= '0;
      r_cand        <= '0;
      r_count       <= '0;
      r_sample_code <= '0;
      r_char_out    <= '0;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      case (r_state)
        LATCH: begin
          r_dec_x  <= accel_x;
          r_dec_y  <= accel_y;
          r_dec_z  <= accel_z;
          r_to_cnt <= '0;
          if (w_entry_below) begin
            r_cand  <= '0;
            r_count <= '0;
          end
        end
        WAIT_DEC: begin
          r_to_cnt <= r_to_cnt + 1'b1;
          if (dec_valid) begin
            r_sample_code <= dec_ascii;
          end else if (w_to_expire) begin
            r_cand  <= '0;
            r_count <= '0;
          end
        end
        COMPARE: begin
          r_cand  <= w_cand_new;
          r_count <= w_cnt_new;
          if (w_cnt_new == c_stable) begin
            r_char_out <= w_cand_new;
          end
        end
        EMIT: begin
          if (char_ready) begin
            r_cand  <= '0;
            r_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dec_x       = r_dec_x;
  assign dec_y       = r_dec_y;
  assign dec_z       = r_dec_z;
  assign char_out    = r_char_out;
  assign char_valid  = (r_state == EMIT);
  assign busy        = (r_state != WAIT_TICK);
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
